bnn_accum_binarize_unit: RTL and testbench

//  Parametrised per-channel accumulate/binarise back end for the BNN datapath.
//  - Takes streamed signed partial sums from the BPU groups and adds them onto per-channel bias.
//  - Binarises each channel: bit = 1 when acc >= 0.
//  - Optionally OR-pools POOL_K consecutive windows into one result.
//  - Hands out one N_CH-bit result per output pixel over a valid/ready interface.

---
 rtl/bnn_accum_binarize_unit_pkg.sv | 30 +++
 rtl/bnn_accum_binarize_unit_if.sv | 26 ++
 rtl/bnn_accum_binarize_unit_sat_acc.sv | 29 ++
 rtl/bnn_accum_binarize_unit.sv | 102 ++++++++++
 tb/tb_bnn_accum_binarize_unit.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bnn_accum_binarize_unit_pkg.sv
// rtl/bnn_accum_binarize_unit_pkg.sv - shared state enum, default widths and sext/sat helpers
package bnn_pkg;

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_BIN, S_EMIT} state_t;

   localparam int DEF_N_CH   = 8;
   localparam int DEF_PSUM_W = 7;
   localparam int DEF_BIAS_W = 8;
   localparam int DEF_ACC_W  = 10;
   localparam int DEF_POOL_K = 4;

   // Sign-extend the low w bits of v to 32 bits.
   function automatic logic signed [31:0] sext(input logic [31:0] v, input int w);
      logic [31:0] m;
      m = 32'hFFFF_FFFF << w;
      return signed'(v[w-1] ? (v | m) : (v & ~m));
   endfunction

   // Clamp v into the signed range of a w-bit number.
   function automatic logic signed [31:0] sat(input logic signed [31:0] v, input int w);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (w - 1)) - 32'sd1;
      lo = -hi - 32'sd1;
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/bnn_accum_binarize_unit_if.sv
// rtl/bnn_accum_binarize_unit_if.sv - partial-sum input stream and binary result output
interface bnn_accum_binarize_unit_if
   import bnn_pkg::*;
#(
   parameter int N_CH   = DEF_N_CH,
   parameter int PSUM_W = DEF_PSUM_W
);
   logic                     psum_valid;
   logic                     psum_ready;
   logic                     psum_last;
   logic [N_CH*PSUM_W-1:0]   psum_data;
   logic                     out_valid;
   logic                     out_ready;
   logic [N_CH-1:0]          out_data;
   logic [15:0]              out_idx;

   modport master (
      output psum_valid, psum_last, psum_data, out_ready,
      input  psum_ready, out_valid, out_data, out_idx
   );

   modport slave (
      input  psum_valid, psum_last, psum_data, out_ready,
      output psum_ready, out_valid, out_data, out_idx
   );
endinterface

// File: rtl/bnn_accum_binarize_unit_sat_acc.sv
// rtl/bnn_accum_binarize_unit_sat_acc.sv - one channel's saturating accumulator with sign output
module bnn_sat_acc
   import bnn_pkg::*;
#(
   parameter int ACC_W  = DEF_ACC_W,
   parameter int PSUM_W = DEF_PSUM_W,
   parameter int BIAS_W = DEF_BIAS_W
)(
   input  logic              clk,
   input  logic              clear,
   input  logic              load,
   input  logic              add,
   input  logic [BIAS_W-1:0] bias,
   input  logic [PSUM_W-1:0] psum,
   output logic              nonneg
);
   logic [ACC_W-1:0] acc;

   always_ff @(posedge clk) begin
      if (clear)
         acc <= '0;
      else if (load)
         acc <= ACC_W'(sext(32'(bias), BIAS_W));
      else if (add)
         acc <= ACC_W'(sat(sext(32'(acc), ACC_W) + sext(32'(psum), PSUM_W), ACC_W));
   end

   assign nonneg = ~acc[ACC_W-1];
endmodule

// File: rtl/bnn_accum_binarize_unit.sv
// rtl/bnn_accum_binarize_unit.sv - per-channel bias accumulate, binarise and optional OR-pool
module bnn_accum_binarize_unit
   import bnn_pkg::*;
#(
   parameter int N_CH   = DEF_N_CH,
   parameter int PSUM_W = DEF_PSUM_W,
   parameter int BIAS_W = DEF_BIAS_W,
   parameter int ACC_W  = DEF_ACC_W,
   parameter int POOL_K = DEF_POOL_K
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   bias_wr,
   input  logic [N_CH*BIAS_W-1:0] bias_in,
   input  logic                   start,
   output logic                   start_ready,
   input  logic                   pool_en,
   bnn_accum_binarize_unit_if.slave bus
);
   state_t                 state;
   logic [N_CH*BIAS_W-1:0] bias;
   logic [N_CH-1:0]        pool_reg;
   logic [4:0]             pool_cnt;
   logic                   pool_mode;
   logic [N_CH-1:0]        bin;
   logic                   load;
   logic                   add;

   assign load = (state == S_IDLE) && start;
   assign add  = (state == S_ACCUM) && bus.psum_valid;

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      bnn_sat_acc #(.ACC_W(ACC_W), .PSUM_W(PSUM_W), .BIAS_W(BIAS_W)) u_acc (
         .clk    (clk),
         .clear  (rst),
         .load   (load),
         .add    (add),
         .bias   (bias[c*BIAS_W +: BIAS_W]),
         .psum   (bus.psum_data[c*PSUM_W +: PSUM_W]),
         .nonneg (bin[c])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         bias           <= '0;
         pool_reg       <= '0;
         pool_cnt       <= '0;
         pool_mode      <= 1'b0;
         start_ready    <= 1'b1;
         bus.psum_ready <= 1'b0;
         bus.out_valid  <= 1'b0;
         bus.out_data   <= '0;
         bus.out_idx    <= '0;
      end else begin
         // The accumulators load the old bias on the start edge, so a write lands next window.
         if (bias_wr)
            bias <= bias_in;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state          <= S_ACCUM;
                  start_ready    <= 1'b0;
                  bus.psum_ready <= 1'b1;
                  if (pool_cnt == 5'd0)
                     pool_mode <= pool_en;
               end
            end
            S_ACCUM: begin
               if (bus.psum_valid && bus.psum_last) begin
                  state          <= S_BIN;
                  bus.psum_ready <= 1'b0;
               end
            end
            S_BIN: begin
               if (pool_mode && (pool_cnt < 5'(POOL_K - 1))) begin
                  pool_reg    <= pool_reg | bin;
                  pool_cnt    <= pool_cnt + 5'd1;
                  state       <= S_IDLE;
                  start_ready <= 1'b1;
               end else begin
                  bus.out_data  <= pool_mode ? (pool_reg | bin) : bin;
                  bus.out_valid <= 1'b1;
                  pool_reg      <= '0;
                  pool_cnt      <= '0;
                  state         <= S_EMIT;
               end
            end
            S_EMIT: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.out_idx   <= bus.out_idx + 16'd1;
                  state         <= S_IDLE;
                  start_ready   <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bnn_accum_binarize_unit.sv
// tb/tb_bnn_accum_binarize_unit.sv - directed stimulus with a queued scoreboard on the result port
module tb_bnn_accum_binarize_unit;
   localparam int N  = 8;
   localparam int PW = 7;
   localparam int BW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          bias_wr = 1'b0;
   logic [N*BW-1:0] bias_in = '0;
   logic          start = 1'b0;
   logic          start_ready;
   logic          pool_en = 1'b0;

   int            errors = 0;
   int            checks = 0;
   logic [23:0]   sb[$];
   logic [15:0]   exp_idx = '0;

   bnn_accum_binarize_unit_if #(.N_CH(N), .PSUM_W(PW)) bus ();

   bnn_accum_binarize_unit #(.N_CH(N), .PSUM_W(PW), .BIAS_W(BW), .ACC_W(10), .POOL_K(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .bias_wr     (bias_wr),
      .bias_in     (bias_in),
      .start       (start),
      .start_ready (start_ready),
      .pool_en     (pool_en),
      .bus         (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [N*PW-1:0] all_psum(input int v);
      logic [N*PW-1:0] w;
      for (int i = 0; i < N; i++) w[i*PW +: PW] = PW'(v);
      return w;
   endfunction

   function automatic logic [N*PW-1:0] put_psum(input logic [N*PW-1:0] w, input int ch, input int v);
      w[ch*PW +: PW] = PW'(v);
      return w;
   endfunction

   function automatic logic [N*BW-1:0] all_bias(input int v);
      logic [N*BW-1:0] w;
      for (int i = 0; i < N; i++) w[i*BW +: BW] = BW'(v);
      return w;
   endfunction

   // Monitor: every accepted result is matched against the oldest expectation.
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_result", 32'(bus.out_data), 32'hFFFF_FFFF);
         end else begin
            logic [23:0] e;
            e = sb.pop_front();
            chk("out_data", 32'(bus.out_data), 32'(e[7:0]));
            chk("out_idx", 32'(bus.out_idx), 32'(e[23:8]));
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_bias(input logic [N*BW-1:0] b);
      bias_wr = 1'b1;
      bias_in = b;
      tick();
      bias_wr = 1'b0;
   endtask

   task automatic open_win(input logic pe);
      start   = 1'b1;
      pool_en = pe;
      tick();
      start   = 1'b0;
      pool_en = 1'b0;
      chk("psum_ready_accum", 32'(bus.psum_ready), 32'd1);
   endtask

   task automatic beat(input logic [N*PW-1:0] d, input logic last);
      bus.psum_valid = 1'b1;
      bus.psum_data  = d;
      bus.psum_last  = last;
      tick();
      bus.psum_valid = 1'b0;
      bus.psum_last  = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!start_ready && n < 20) begin
         tick();
         n++;
      end
      chk("idle_timeout", 32'(start_ready), 32'd1);
   endtask

   task automatic close_win(input logic exp_out, input logic [7:0] exp_data);
      if (exp_out) begin
         sb.push_back({exp_idx, exp_data});
         exp_idx++;
      end
      chk("bin_no_valid", 32'(bus.out_valid), 32'd0);
      tick();
      chk("emit_valid", 32'(bus.out_valid), 32'(exp_out));
      if (!exp_out)
         chk("pool_back_idle", 32'(start_ready), 32'd1);
      else if (bus.out_ready)
         wait_idle();
   endtask

   initial begin
      bus.psum_valid = 1'b0;
      bus.psum_last  = 1'b0;
      bus.psum_data  = '0;
      bus.out_ready  = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_start_ready", 32'(start_ready), 32'd1);
      chk("rst_psum_ready", 32'(bus.psum_ready), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_data", 32'(bus.out_data), 32'd0);
      chk("rst_out_idx", 32'(bus.out_idx), 32'd0);

      // Basic: ch0 5-6=-1, ch1 5+3=8, the rest stay at 5.
      set_bias(all_bias(5));
      open_win(1'b0);
      for (int i = 0; i < 3; i++) beat(put_psum(put_psum(all_psum(0), 0, -2), 1, 1), i == 2);
      close_win(1'b1, 8'hFE);

      // Saturation both ways, then come back down from the positive clamp.
      set_bias(all_bias(127));
      open_win(1'b0);
      for (int i = 0; i < 10; i++) beat(all_psum(63), i == 9);
      close_win(1'b1, 8'hFF);
      set_bias(all_bias(-128));
      open_win(1'b0);
      for (int i = 0; i < 10; i++) beat(all_psum(-64), i == 9);
      close_win(1'b1, 8'h00);
      set_bias(all_bias(127));
      open_win(1'b0);
      for (int i = 0; i < 9; i++) beat(all_psum(63), 1'b0);
      for (int i = 0; i < 8; i++) beat(all_psum(-64), i == 7);
      close_win(1'b1, 8'h00);

      // Pooling over four windows; pool_en on later starts must not matter.
      set_bias(all_bias(-1));
      for (int k = 0; k < 4; k++) begin
         int ch;
         ch = (k == 3) ? 7 : k;
         open_win(k == 0);
         beat(put_psum(all_psum(0), ch, 1), 1'b1);
         close_win(k == 3, 8'h87);
      end
      open_win(1'b0);
      beat(put_psum(all_psum(0), 2, 1), 1'b1);
      close_win(1'b1, 8'h04);

      // Backpressure in EMIT with stray start and psum_valid.
      set_bias(all_bias(0));
      bus.out_ready = 1'b0;
      open_win(1'b0);
      beat(put_psum(all_psum(0), 3, -5), 1'b1);
      close_win(1'b1, 8'hF7);
      for (int i = 0; i < 5; i++) begin
         start = 1'b1;
         bus.psum_valid = 1'b1;
         tick();
         chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
         chk("bp_out_data", 32'(bus.out_data), 32'hF7);
         chk("bp_start_ready", 32'(start_ready), 32'd0);
         chk("bp_psum_ready", 32'(bus.psum_ready), 32'd0);
      end
      start = 1'b0;
      bus.psum_valid = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
      chk("bp_release_idle", 32'(start_ready), 32'd1);

      // psum_valid in IDLE is not accepted.
      bus.psum_valid = 1'b1;
      bus.psum_data  = all_psum(-64);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("idle_psum_ready", 32'(bus.psum_ready), 32'd0);
      end
      bus.psum_valid = 1'b0;
      open_win(1'b0);
      beat(all_psum(0), 1'b1);
      close_win(1'b1, 8'hFF);

      // bias_wr mid-window only affects the following window.
      open_win(1'b0);
      beat(all_psum(-1), 1'b0);
      set_bias(all_bias(10));
      beat(all_psum(0), 1'b1);
      close_win(1'b1, 8'h00);
      open_win(1'b0);
      beat(all_psum(-1), 1'b1);
      close_win(1'b1, 8'hFF);

      // Reset in the middle of a window.
      set_bias(all_bias(-100));
      open_win(1'b0);
      beat(all_psum(3), 1'b0);
      beat(all_psum(3), 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sb.delete();
      exp_idx = '0;
      chk("mid_rst_start_ready", 32'(start_ready), 32'd1);
      chk("mid_rst_psum_ready", 32'(bus.psum_ready), 32'd0);
      chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_out_data", 32'(bus.out_data), 32'd0);
      chk("mid_rst_out_idx", 32'(bus.out_idx), 32'd0);
      open_win(1'b0);
      beat(all_psum(-1), 1'b1);
      close_win(1'b1, 8'h00);
      open_win(1'b0);
      beat(all_psum(0), 1'b1);
      close_win(1'b1, 8'hFF);

      tick();
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
